uart_tx_feeder: RTL and testbench

//  Byte-buffering front end for the UART transmitter, in the bclk (16x baud) domain.

---
 rtl/uart_defs.sv | 15 +
 rtl/uart_byte_fifo.sv | 65 ++++++
 rtl/uart_tx_feeder.sv | 97 +++++++++
 tb/tb_uart_tx_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// uart_defs: shared encodings for the UART transmit feeder.
// FSM states and the UART data width.
package uart_defs;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: simple synchronous byte FIFO, 2**DEPTH_LOG2 deep.
// Combinational head read; full/empty registered from next level.
module uart_byte_fifo
  import uart_defs::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE =
    {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wptr;
  logic [DEPTH_LOG2-1:0]  rptr;
  logic [DEPTH_LOG2:0]    level_nxt;
  logic                   push;
  logic                   pop;

  // A push into a full FIFO is allowed only when the head leaves this cycle.
  always_comb begin
    pop       = rd && !empty;
    push      = wr && (!full || pop);
    level_nxt = level;
    if (push && !pop) level_nxt = level + LVL_ONE;
    if (pop && !push) level_nxt = level - LVL_ONE;
  end

  assign rd_data = mem[rptr];

  // Storage; on push+pop at full, wptr==rptr and the old head is read first.
  always_ff @(posedge bclk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // Pointers, level and registered flags.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered start/tx_din driver for uart_tx (bclk domain).
// Define UART_TX_FEEDER_OVF_CNT_EN to count dropped pushes in ovf_cnt.
module uart_tx_feeder
  import uart_defs::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   bclk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   start,
  output logic [UART_DATA_W-1:0] tx_din,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [7:0]             ovf_cnt
);

  feeder_state_t          state;
  feeder_state_t          state_nxt;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .bclk    (bclk),
    .rst     (rst),
    .wr      (wr_en),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // State register.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state, pop strobe and the single-cycle start pulse.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && tx_done) begin
          pop       = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  state_nxt = ST_START;
      ST_START: begin
        start     = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!tx_done) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte handed to the transmitter; held until the next pop.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst)     tx_din <= '0;
    else if (pop) tx_din <= head;
  end

  assign busy = (state != ST_IDLE);

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic drop;
  assign drop = wr_en && full && !pop;

  // Saturating dropped-byte counter.
  always_ff @(posedge bclk or negedge rst) begin
    if (!rst)
      ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF)
      ovf_cnt <= ovf_cnt + 8'd1;
  end
`else
  assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench with a behavioural transmitter model.
// Expected bytes queue on acceptance; the monitor checks each start pulse.
module tb_uart_tx_feeder;

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       bclk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       start;
  logic [7:0] tx_din;
  logic       tx_done;
  logic       busy;
  logic [7:0] ovf_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         tx_auto;
  bit         prev_start;
  int         start_cnt = 0;

  uart_tx_feeder #(.DEPTH_LOG2(4)) dut (
    .bclk    (bclk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .start   (start),
    .tx_din  (tx_din),
    .tx_done (tx_done),
    .busy    (busy),
    .ovf_cnt (ovf_cnt)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard monitor: every start pulse must carry the oldest accepted byte.
  always @(negedge bclk) begin
    if (start === 1'b1) begin
      start_cnt++;
      chk("start_while_tx_busy", tx_done, 1);
      chk("start_width", prev_start, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_start: got tx_din=%0h expected no frame",
                 tx_din);
      end else begin
        chk("tx_byte", tx_din, exp_q.pop_front());
      end
    end
    prev_start = start;
  end

  // Transmitter model: drops tx_done shortly after start, frame of random length.
  initial begin
    int gap;
    gap = -1;
    forever begin
      @(negedge bclk);
      if (gap >= 0) begin
        gap++;
        if (gap > 12) begin
          fail("frame_gap_timeout");
          gap = -1;
        end
      end
      if (tx_auto && start === 1'b1) begin
        if (gap >= 0) chk("frame_gap", gap, 3);
        gap = -1;
        repeat ($urandom_range(1, 3)) @(negedge bclk);
        tx_done = 1'b0;
        repeat ($urandom_range(6, 20)) @(negedge bclk);
        tx_done = 1'b1;
        #1;
        if (tx_auto && exp_q.size() > 0) gap = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit keep);
    wr_en   = 1'b1;
    wr_data = b;
    if (keep) exp_q.push_back(b);
    @(negedge bclk);
    wr_en = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge bclk);
      if (start === 1'b1) return;
    end
    fail("wait_start");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge bclk);
      if (exp_q.size() == 0 && empty && !busy && tx_done) return;
    end
    fail("wait_idle");
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_tx_din"}, tx_din, 8'h00);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, ovf_cnt, 0);
  endtask

  initial begin
    int n;
    int saved;
    rst     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_done = 1'b1;
    tx_auto = 1'b1;

    // Reset held 5 cycles.
    repeat (5) @(negedge bclk);
    chk_reset("reset");
    rst = 1'b1;
    repeat (2) @(negedge bclk);

    // Single byte: start exactly during the third cycle after the push.
    push_byte(8'hA5, 1'b1);
    chk("lat_c1_start", start, 0);
    @(negedge bclk);
    chk("lat_c2_start", start, 0);
    chk("lat_c2_busy", busy, 1);
    @(negedge bclk);
    chk("lat_c3_start", start, 1);
    chk("lat_c3_tx_din", tx_din, 8'hA5);
    @(negedge bclk);
    chk("lat_c4_start", start, 0);
    wait_idle();

    // Burst of three, queued while the transmitter is held busy.
    tx_auto = 1'b0;
    tx_done = 1'b0;
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    chk("burst_level3", level, 3);
    tx_auto = 1'b1;
    tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_start();
      chk("burst_level", level, 2 - i);
    end
    wait_idle();

    // Randomized traffic against the transmitter model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        push_byte(8'($urandom), 1'b1);
        repeat ($urandom_range(0, 3)) @(negedge bclk);
      end
      wait_idle();
      chk("drain_level", level, 0);
    end

    // Overflow: 17 pushes with the transmitter stalled; the last is dropped.
    tx_auto = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'(i), i < 16);
    chk("ovf_full", full, 1);
    chk("ovf_empty", empty, 0);
    chk("ovf_level", level, 16);
    chk("ovf_cnt", ovf_cnt, OVF_ON ? 1 : 0);

    // Push while full on the very cycle the head is popped.
    tx_auto = 1'b1;
    tx_done = 1'b1;
    push_byte(8'h55, 1'b1);
    chk("popfull_level", level, 16);
    chk("popfull_full", full, 1);
    chk("popfull_ovf", ovf_cnt, OVF_ON ? 1 : 0);
    wait_idle();

    // Counter saturation with many dropped pushes.
    tx_auto = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom), 1'b1);
    for (int i = 0; i < 300; i++) push_byte(8'hEE, 1'b0);
    chk("sat_level", level, 16);
    chk("sat_ovf", ovf_cnt, OVF_ON ? 8'hFF : 8'h00);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk_reset("async_reset");
    repeat (3) @(negedge bclk);
    rst = 1'b1;
    tx_done = 1'b1;
    tx_auto = 1'b1;
    @(negedge bclk);

    // Reset in the middle of a frame discards the rest.
    push_byte(8'h3C, 1'b1);
    push_byte(8'hC3, 1'b1);
    wait_start();
    repeat (4) @(negedge bclk);
    chk("midframe_busy", busy, 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk_reset("midframe_reset");
    repeat (2) @(negedge bclk);
    rst = 1'b1;
    saved = start_cnt;
    repeat (40) @(negedge bclk);
    chk("post_reset_starts", start_cnt, saved);
    chk("post_reset_empty", empty, 1);
    chk("post_reset_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
